// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator for the ALU operand/command pins. Takes one operation per
// valid/ready request, holds the ALU pins and CE for the command-dependent
// latency, then captures RES/flags into a response register that is held
// until the consumer accepts it. One operation outstanding at a time.
// Optional feature macro: ALU_SEQ_ERRCNT_EN adds a saturating err_count
// output that counts captured responses with the ERR flag set.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
   parameter int unsigned    N        = 8,
   parameter int unsigned    M        = 4,
   parameter int unsigned    LAT_STD  = 2,
   parameter int unsigned    LAT_MUL  = 3,
   parameter logic [M-1:0]   MUL_CMD0 = M'(9),
   parameter logic [M-1:0]   MUL_CMD1 = M'(10)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [N-1:0]     req_opa,
   input  logic [N-1:0]     req_opb,
   input  logic [M-1:0]     req_cmd,
   input  logic             req_mode,
   input  logic             req_cin,
   input  logic [1:0]       req_inp_valid,
   output logic [N-1:0]     OPA,
   output logic [N-1:0]     OPB,
   output logic [M-1:0]     CMD,
   output logic             MODE,
   output logic             CIN,
   output logic             CE,
   output logic [1:0]       INP_VALID,
   input  logic [2*N-1:0]   alu_res,
   input  logic [5:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [2*N-1:0]   rsp_res,
   output logic [5:0]       rsp_flags,
   output logic             busy
`ifdef ALU_SEQ_ERRCNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   localparam int unsigned LAT_MAX = (LAT_STD > LAT_MUL) ? LAT_STD : LAT_MUL;
   localparam int unsigned CW      = $clog2(LAT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   // r_run keeps req_ready low while RST is held and for the cycle it is released into
   logic             r_run;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    r_lat;
   logic [CW-1:0]    w_lat_sel;
   logic             w_is_mul;
   logic             w_accept;
   logic             w_capture;

   logic [N-1:0]     r_opa;
   logic [N-1:0]     r_opb;
   logic [M-1:0]     r_cmd;
   logic             r_mode;
   logic             r_cin;
   logic             r_ce;
   logic [1:0]       r_inp_valid;
   logic             r_rsp_valid;
   logic [2*N-1:0]   r_rsp_res;
   logic [5:0]       r_rsp_flags;

   assign w_is_mul  = req_mode && ((req_cmd == MUL_CMD0) || (req_cmd == MUL_CMD1));
   assign w_lat_sel = w_is_mul ? CW'(LAT_MUL) : CW'(LAT_STD);
   assign w_accept  = (r_state == S_IDLE) && r_run && req_valid;
   assign w_capture = (r_state == S_WAIT) && (r_cnt == r_lat);

   // State register plus the post-reset run flag
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_run   <= 1'b1;
      end
   end

   // Next-state: IDLE -> ISSUE -> WAIT (until latency reached) -> RESP (until accepted)
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)  w_state_next = S_ISSUE;
         S_ISSUE:                w_state_next = S_WAIT;
         S_WAIT:  if (w_capture) w_state_next = S_RESP;
         S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   // Handshake/status outputs decoded from the current state
   always_comb begin
      req_ready = (r_state == S_IDLE) && r_run;
      busy      = (r_state != S_IDLE);
   end

   // Pin, latency counter and response registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_opa       <= '0;
         r_opb       <= '0;
         r_cmd       <= '0;
         r_mode      <= 1'b0;
         r_cin       <= 1'b0;
         r_inp_valid <= 2'b00;
         r_ce        <= 1'b0;
         r_lat       <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_res   <= '0;
         r_rsp_flags <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_opa       <= req_opa;
                  r_opb       <= req_opb;
                  r_cmd       <= req_cmd;
                  r_mode      <= req_mode;
                  r_cin       <= req_cin;
                  r_inp_valid <= req_inp_valid;
                  r_ce        <= 1'b1;
                  r_lat       <= w_lat_sel;
               end
            end
            S_ISSUE: begin
               // this edge is the one the ALU samples on; latency counts from here
               r_cnt <= CW'(1);
            end
            S_WAIT: begin
               if (w_capture) begin
                  r_rsp_res   <= alu_res;
                  r_rsp_flags <= alu_flags;
                  r_rsp_valid <= 1'b1;
                  r_ce        <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) r_rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_ERRCNT_EN
   logic [7:0] r_err_cnt;

   // Saturating count of captured responses flagged ERR; cleared by RST only
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_err_cnt <= 8'h00;
      end else if (w_capture && alu_flags[0] && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'h01;
      end
   end

   assign err_count = r_err_cnt;
`endif

   assign OPA       = r_opa;
   assign OPB       = r_opb;
   assign CMD       = r_cmd;
   assign MODE      = r_mode;
   assign CIN       = r_cin;
   assign CE        = r_ce;
   assign INP_VALID = r_inp_valid;
   assign rsp_valid = r_rsp_valid;
   assign rsp_res   = r_rsp_res;
   assign rsp_flags = r_rsp_flags;

endmodule
